aes_inv_key_schedule: RTL and testbench
=======================================

// Module: aes_inv_key_schedule
// PURPOSE
//  Sequential AES-128 inverse key schedule for the decryption datapath. Takes the round-10 key
//  and walks the expansion backwards, emitting round keys 10,9,...,0 one per output handshake,
//  in the order the inverse cipher consumes them. One SubWord evaluation per beat, not 10 in parallel.
// PARAMETERS
//  NR     10  number of rounds; only 10 (AES-128) is supported
//  RND_W  4   width of the round index
// PORTS
//  i_aes_inv_key_schedule_clk       in   1    clock; all state updates on its rising edge
//  i_aes_inv_key_schedule_rst       in   1    reset; synchronous, active-high
//  i_aes_inv_key_schedule_key_valid in   1    load request
//  o_aes_inv_key_schedule_key_ready out  1    load accepted when valid&ready
//  i_aes_inv_key_schedule_key       in   128  round-10 key (cipher key with the optional feature); column0 = [127:96]
//  o_aes_inv_key_schedule_rk_valid  out  1    round key available
//  i_aes_inv_key_schedule_rk_ready  in   1    consumer accepts the round key
//  o_aes_inv_key_schedule_rk        out  128  current round key; column0 = [127:96]
//  o_aes_inv_key_schedule_rk_round  out  4    round index of rk (10 down to 0)
//  o_aes_inv_key_schedule_rk_last   out  1    high with the round-0 beat
//  o_aes_inv_key_schedule_busy      out  1    high whenever not IDLE
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE; rk=0, rk_round=0, rk_valid=0, rk_last=0, busy=0.
//    key_ready=1 from the first cycle after reset. Reset mid-operation abandons the sequence.
//  - FSM: IDLE -> STREAM -> IDLE. EXPAND exists only under the macro.
//  - IDLE: key_ready=1. On valid&ready: rk<=key, rk_round<=10, and the FSM enters STREAM.
//    rk_valid=1 the next cycle (latency 1).
//  - STREAM: key_ready=0. rk_valid stays high, and rk/rk_round/rk_last stay stable while rk_ready=0.
//  - On rk_valid&rk_ready with rk_round=r>0, for current columns {c0,c1,c2,c3}:
//    p3=c3^c2; p2=c2^c1; p1=c1^c0; p0=c0^SubWord(RotWord(p3))^{RCON[r],24'h0}.
//    rk<={p0,p1,p2,p3}; rk_round<=r-1. RotWord = {w[23:0],w[31:24]}.
//  - RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36; constant table, no runtime GF arithmetic.
//  - rk_last = rk_valid & (rk_round==0). On the last handshake: rk_valid<=0, FSM->IDLE.
//    key_ready returns high the following cycle, so there is a 1-cycle gap between sequences.
//  - key_valid outside IDLE is ignored (no latching, no error).
//  - Exactly 11 rk handshakes per accepted key; rk holds its last value in IDLE.
// CONFIGURATION
//  AES_INV_KEY_SCHEDULE_FWD_EN defined:
//    - the input key is the cipher key (round 0).
//    - the accept moves IDLE->EXPAND; EXPAND runs 10 forward steps, one per cycle:
//      n0=c0^SubWord(RotWord(c3))^RCON[i]; n1=c1^n0; n2=c2^n1; n3=c3^n2; i=1..10.
//    - then STREAM from round 10. First rk_valid arrives 11 cycles after the accept.
//    - busy=1, key_ready=0 and rk_valid=0 during EXPAND. The same SubWord instance is shared.
//  Undefined: no EXPAND state or logic; the input must be the round-10 key; latency 1.
// STRUCTURE
//  - Shared package aes_pkg:
//    - RCON table (32-bit words, index 1..10), NR, RND_W;
//    - state enum {IDLE, EXPAND, STREAM};
//    - rot_word function.
//  - One sub-module, aes_sub_word: 32-bit in/out, four combinational S-box lookups using the same
//    S-box table as aes_sub_bytes. Single instance, muxed input (p3 in STREAM, c3 in EXPAND).
// TESTING
//  1. Load d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1 -> 11 back-to-back beats:
//     beat0=d014f9a8..., beat1=ac7766f319fadc2128d12941575c006e,
//     beat9=a0fafe1788542cb123a339392a6c7605,
//     beat10=2b7e151628aed2a6abf7158809cf4f3c with rk_round=0, rk_last=1.
//  2. Load b4ef5bcb3e92e21123e951cf6f8f188e -> beat10 = 128'h0, rk_last=1; key_ready=1 one cycle later.
//  3. Test 1 with random rk_ready stalls -> identical 11-key sequence;
//     rk/rk_round unchanged on every cycle with rk_valid&!rk_ready.
//  4. Assert key_valid continuously through STREAM -> key_ready=0 and no reload until after beat10;
//     second key accepted exactly 1 cycle after last, rk_round restarts at 10.
//  5. Reset during beat 5 -> next cycle rk_valid=0, busy=0, key_ready=1, rk=0;
//     a fresh load reproduces test 1 from beat0.
//  6. FWD_EN build: load 2b7e151628aed2a6abf7158809cf4f3c -> busy for 10 EXPAND cycles,
//     first rk_valid 11 cycles after accept with rk=d014f9a8..., then same sequence as test 1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule: FSM states, round constants,
// S-box table and the RotWord helper.
package aes_pkg;

  localparam int unsigned NR    = 10;
  localparam int unsigned RND_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    STREAM = 2'd2
  } state_e;

  // Round constants as full words; index 1..10 used, remaining entries zero.
  localparam logic [31:0] RCON [16] = '{
    32'h00000000, 32'h01000000, 32'h02000000, 32'h04000000,
    32'h08000000, 32'h10000000, 32'h20000000, 32'h40000000,
    32'h80000000, 32'h1b000000, 32'h36000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
  };

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b lives at bit offset (255-b)*8, i.e. {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four combinational S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word_c
);

  // Substitute each byte independently
  always_comb begin
    o_word_c = '0;
    for (int i = 0; i < 4; i++) begin
      o_word_c[8*i +: 8] = sbox(i_word[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: streams round keys 10..0 from the round-10 key,
// one SubWord per beat. Optional macro AES_INV_KEY_SCHEDULE_FWD_EN accepts the
// cipher key instead and first expands forward to round 10 in an EXPAND phase.
module aes_inv_key_schedule
  import aes_pkg::*;
(
  input  logic               i_aes_inv_key_schedule_clk,
  input  logic               i_aes_inv_key_schedule_rst,
  input  logic               i_aes_inv_key_schedule_key_valid,
  output logic               o_aes_inv_key_schedule_key_ready,
  input  logic [127:0]       i_aes_inv_key_schedule_key,
  output logic               o_aes_inv_key_schedule_rk_valid,
  input  logic               i_aes_inv_key_schedule_rk_ready,
  output logic [127:0]       o_aes_inv_key_schedule_rk,
  output logic [RND_W-1:0]   o_aes_inv_key_schedule_rk_round,
  output logic               o_aes_inv_key_schedule_rk_last,
  output logic               o_aes_inv_key_schedule_busy
);

  state_e             state_q, state_d;
  logic [127:0]       rk_q, rk_d;
  logic [RND_W-1:0]   rk_round_q, rk_round_d;
  logic               rk_valid_q, rk_valid_d;
  logic               rk_last_q, rk_last_d;
  logic               key_ready_q, key_ready_d;
  logic               busy_q, busy_d;

  logic [31:0] c0, c1, c2, c3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] sw_in, sw_out;

  assign {c0, c1, c2, c3} = rk_q;

  // Backward step: recover the previous round key from the current one.
  assign p3 = c3 ^ c2;
  assign p2 = c2 ^ c1;
  assign p1 = c1 ^ c0;
  assign p0 = c0 ^ sw_out ^ RCON[rk_round_q];

`ifdef AES_INV_KEY_SCHEDULE_FWD_EN
  logic [RND_W-1:0] step;
  logic [31:0]      n0, n1, n2, n3;

  // In EXPAND rk_round_q counts completed forward steps.
  assign step = rk_round_q + RND_W'(1);
  assign n0   = c0 ^ sw_out ^ RCON[step];
  assign n1   = c1 ^ n0;
  assign n2   = c2 ^ n1;
  assign n3   = c3 ^ n2;
  assign sw_in = (state_q == EXPAND) ? rot_word(c3) : rot_word(p3);
`else
  assign sw_in = rot_word(p3);
`endif

  aes_sub_word u_sub_word (
    .i_word   (sw_in),
    .o_word_c (sw_out)
  );

  // Next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    rk_d        = rk_q;
    rk_round_d  = rk_round_q;
    rk_valid_d  = rk_valid_q;
    rk_last_d   = rk_last_q;
    key_ready_d = key_ready_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        key_ready_d = 1'b1;
        if (i_aes_inv_key_schedule_key_valid && key_ready_q) begin
          rk_d        = i_aes_inv_key_schedule_key;
          key_ready_d = 1'b0;
          busy_d      = 1'b1;
          rk_last_d   = 1'b0;
`ifdef AES_INV_KEY_SCHEDULE_FWD_EN
          state_d     = EXPAND;
          rk_round_d  = '0;
`else
          state_d     = STREAM;
          rk_round_d  = RND_W'(NR);
          rk_valid_d  = 1'b1;
`endif
        end
      end
`ifdef AES_INV_KEY_SCHEDULE_FWD_EN
      EXPAND: begin
        rk_d       = {n0, n1, n2, n3};
        rk_round_d = step;
        if (step == RND_W'(NR)) begin
          state_d    = STREAM;
          rk_valid_d = 1'b1;
        end
      end
`endif
      STREAM: begin
        if (i_aes_inv_key_schedule_rk_ready) begin
          if (rk_round_q == '0) begin
            state_d     = IDLE;
            rk_valid_d  = 1'b0;
            rk_last_d   = 1'b0;
            busy_d      = 1'b0;
            key_ready_d = 1'b1;
          end else begin
            rk_d       = {p0, p1, p2, p3};
            rk_round_d = rk_round_q - RND_W'(1);
            rk_last_d  = (rk_round_q == RND_W'(1));
          end
        end
      end
      default: begin
        state_d     = IDLE;
        rk_valid_d  = 1'b0;
        rk_last_d   = 1'b0;
        busy_d      = 1'b0;
        key_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_aes_inv_key_schedule_clk) begin
    if (i_aes_inv_key_schedule_rst) begin
      state_q     <= IDLE;
      rk_q        <= '0;
      rk_round_q  <= '0;
      rk_valid_q  <= 1'b0;
      rk_last_q   <= 1'b0;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rk_q        <= rk_d;
      rk_round_q  <= rk_round_d;
      rk_valid_q  <= rk_valid_d;
      rk_last_q   <= rk_last_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign o_aes_inv_key_schedule_key_ready = key_ready_q;
  assign o_aes_inv_key_schedule_rk_valid  = rk_valid_q;
  assign o_aes_inv_key_schedule_rk        = rk_q;
  assign o_aes_inv_key_schedule_rk_round  = rk_round_q;
  assign o_aes_inv_key_schedule_rk_last   = rk_last_q;
  assign o_aes_inv_key_schedule_busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for aes_inv_key_schedule using the FIPS-197 key expansion vectors.
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] key = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] fips [11];
  localparam logic [127:0] K10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K0_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K10_ZERO = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  always #5 clk = ~clk;

  aes_inv_key_schedule dut (
    .i_aes_inv_key_schedule_clk       (clk),
    .i_aes_inv_key_schedule_rst       (rst),
    .i_aes_inv_key_schedule_key_valid (key_valid),
    .o_aes_inv_key_schedule_key_ready (key_ready),
    .i_aes_inv_key_schedule_key       (key),
    .o_aes_inv_key_schedule_rk_valid  (rk_valid),
    .i_aes_inv_key_schedule_rk_ready  (rk_ready),
    .o_aes_inv_key_schedule_rk        (rk),
    .o_aes_inv_key_schedule_rk_round  (rk_round),
    .o_aes_inv_key_schedule_rk_last   (rk_last),
    .o_aes_inv_key_schedule_busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    vectors++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1 || rk !== 128'h0 ||
        rk_round !== 4'd0 || rk_last !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: valid=%b busy=%b ready=%b rk=%h round=%0d last=%b, want 0 0 1 0 0 0",
               tag, rk_valid, busy, key_ready, rk, rk_round, rk_last);
    end
  endtask

  // Present key for one accept; waits (bounded) for key_ready first.
  task automatic load(input logic [127:0] k);
    int g = 0;
    while (key_ready !== 1'b1 && g < 50) begin
      tick();
      g++;
    end
    vectors++;
    if (key_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_ready: key_ready=%b after %0d cycles, want 1", key_ready, g);
    end
    key = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  // Consume all 11 beats; rk checked on every beat when full, else only beats 0 and 10.
  task automatic stream_check(input string tag, input logic [127:0] first_rk,
                              input logic [127:0] last_rk, input bit full,
                              input bit stall, input bit chk_ready_low);
    int b = 0;
    int g = 0;
    logic rdy;
    logic [127:0] want;
    bit rk_ok;
    while (b < 11 && g < 300) begin
      g++;
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rdy;
      want = (b == 0) ? first_rk : (b == 10) ? last_rk : fips[b];
      rk_ok = (!full && b != 0 && b != 10) || (rk === want);
      vectors++;
      if (rk_valid !== 1'b1 || !rk_ok || rk_round !== 4'(10 - b) || rk_last !== (b == 10) ||
          busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s beat%0d: valid=%b rk=%h round=%0d last=%b busy=%b, want 1 %h %0d %b 1",
                 tag, b, rk_valid, rk, rk_round, rk_last, busy, want, 10 - b, b == 10);
      end
      if (chk_ready_low) begin
        vectors++;
        if (key_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_keyready beat%0d: key_ready=%b, want 0", tag, b, key_ready);
        end
      end
      tick();
      if (rdy) b++;
    end
    rk_ready = 1'b0;
    vectors++;
    if (b != 11) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d beats, want 11", tag, b);
    end
    vectors++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0 || rk !== last_rk) begin
      miscompares++;
      $display("FAIL %s_end: valid=%b ready=%b busy=%b rk=%h, want 0 1 0 %h",
               tag, rk_valid, key_ready, busy, rk, last_rk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_idle_reset("reset");
    rst = 1'b0;
    tick();
    check_idle_reset("reset_idle");
  endtask

`ifndef AES_INV_KEY_SCHEDULE_FWD_EN
  task automatic check_first_beat(input string tag, input logic [127:0] k);
    vectors++;
    if (rk_valid !== 1'b1 || rk !== k || rk_round !== 4'd10 || key_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_latency: valid=%b rk=%h round=%0d ready=%b, want 1 %h 10 0",
               tag, rk_valid, rk, rk_round, key_ready, k);
    end
  endtask

  task automatic test_fips_sequence();
    load(K10_FIPS);
    check_first_beat("fips", K10_FIPS);
    stream_check("fips", K10_FIPS, K0_FIPS, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_zero_key();
    load(K10_ZERO);
    check_first_beat("zero", K10_ZERO);
    stream_check("zero", K10_ZERO, 128'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stalls();
    load(K10_FIPS);
    stream_check("stall", K10_FIPS, K0_FIPS, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    key = K10_FIPS;
    key_valid = 1'b1;
    tick();
    check_first_beat("b2b_first", K10_FIPS);
    key = K10_ZERO;
    stream_check("b2b", K10_FIPS, K0_FIPS, 1'b1, 1'b0, 1'b1);
    // key_valid still high: accepted on the edge after key_ready rose
    tick();
    key_valid = 1'b0;
    check_first_beat("b2b_second", K10_ZERO);
    stream_check("b2b_zero", K10_ZERO, 128'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    load(K10_FIPS);
    rk_ready = 1'b1;
    repeat (5) tick();
    rk_ready = 1'b0;
    vectors++;
    if (rk_valid !== 1'b1 || rk_round !== 4'd5 || rk !== fips[5]) begin
      miscompares++;
      $display("FAIL midrst_beat5: valid=%b round=%0d rk=%h, want 1 5 %h",
               rk_valid, rk_round, rk, fips[5]);
    end
    rst = 1'b1;
    tick();
    check_idle_reset("midrst");
    rst = 1'b0;
    load(K10_FIPS);
    check_first_beat("midrst_reload", K10_FIPS);
    stream_check("midrst_reload", K10_FIPS, K0_FIPS, 1'b1, 1'b0, 1'b0);
  endtask
`else
  task automatic test_fwd_expand();
    load(K0_FIPS);
    for (int c = 1; c <= 10; c++) begin
      vectors++;
      if (rk_valid !== 1'b0 || busy !== 1'b1 || key_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL fwd_expand cycle%0d: valid=%b busy=%b ready=%b, want 0 1 0",
                 c, rk_valid, busy, key_ready);
      end
      tick();
    end
    vectors++;
    if (rk_valid !== 1'b1 || rk !== K10_FIPS || rk_round !== 4'd10) begin
      miscompares++;
      $display("FAIL fwd_first: valid=%b rk=%h round=%0d, want 1 %h 10",
               rk_valid, rk, rk_round, K10_FIPS);
    end
    stream_check("fwd", K10_FIPS, K0_FIPS, 1'b1, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    fips[0]  = K10_FIPS;
    fips[1]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[2]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[3]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[4]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[7]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[8]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[9]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[10] = K0_FIPS;

    test_reset();
`ifndef AES_INV_KEY_SCHEDULE_FWD_EN
    test_fips_sequence();
    test_zero_key();
    test_stalls();
    test_back_to_back();
    test_mid_reset();
`else
    test_fwd_expand();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
